mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
Main control FSM for the multi-cycle datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit alu_ct_op, along with all datapath enables and mux selects. It sequences each instruction through fetch, decode, execute, memory and writeback, and stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, when 1 the FETCH, MEM_RD and MEM_WR states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
opcode  input  6  instruction[31:26] from the IR. Stable outside FETCH.
mem_ready  input  1  memory access completes this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond  output  1  PC load when ALU zero is set.
pc_source  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  IR load.
reg_dst  output  1  register write index select: 1 rd, 0 rt.
mem_to_reg  output  1  register write data select: 1 MDR, 0 ALUOut.
reg_write  output  1  register file write enable.
alu_src_a  output  1  ALU A select: 0 PC, 1 reg A.
alu_src_b  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
alu_ct_op  output  2  to the ALU control decoder: 00 add, 01 subtract, 10 R-type by funct, 11 set-less-than.
instr_done  output  1  one-cycle pulse in the final cycle of a retired instruction.
illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
state_dbg  output  4  current state encoding.

Behaviour:
- State register is the only storage. rst low asynchronously forces state to FETCH and every output to 0, including state_dbg=0. Outputs are decoded combinationally from state, plus mem_ready and opcode where noted.
- State encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BEQ 8, JUMP 9, I_EXEC 10, I_WB 11. Unused codes go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_ct_op=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_ct_op=00 (branch target precomputed). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEM_ADR.
  - 000000: R_EXEC.
  - 000100: BEQ.
  - 000010: JUMP.
  - 001001 (addiu) or 001010 (slti): I_EXEC.
  - Any other opcode: FETCH with illegal_op=1; no write strobe asserted.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1; in the ready cycle instr_done=1, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ct_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Goes to FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_ct_op=11 when opcode=001010, otherwise 00. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- Latency with mem_ready held at 1:
  - lw: 5 cycles.
  - R-type, addiu, slti, sw: 4 cycles.
  - beq, j: 3 cycles.
  - Each wait cycle adds 1.
- Reset mid-instruction: no write strobe may appear after rst falls. The first state after release is FETCH.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 during reset; state_dbg=0 on release; mem_read=1 in the first cycle after release.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_ct_op=10 in R_EXEC; reg_write=1 and reg_dst=1 only in R_WB; exactly one instr_done pulse.
- lw with 2 wait cycles in MEM_RD: opcode=100011, mem_ready low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles; then MEM_WB with mem_to_reg=1; total 7 cycles.
- sw then beq: opcode=101011, then 000100 -> mem_write=1 only in the MEM_WR ready cycle; BEQ shows alu_ct_op=01, pc_write_cond=1, pc_source=01.
- slti vs addiu: opcode=001010, then 001001 -> alu_ct_op=11 and 00 respectively in I_EXEC; I_WB has reg_write=1, reg_dst=0.
- Illegal and mid-op reset: opcode=111111 -> illegal_op pulse in DECODE, next state 0, no writes. Separately, assert rst=0 in MEM_WR while mem_ready=0 -> mem_write drops immediately; state_dbg=0.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable, mux select and the ALU op class.
module mc_main_ctrl #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_ct_op,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   state_t state, state_nxt;
   logic   rdy;
   logic   op_legal;

   assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_comb begin
      case (opcode)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDIU, OP_SLTI: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:      state_nxt = S_MEMADR;
               OP_RTYPE:          state_nxt = S_REXEC;
               OP_BEQ:            state_nxt = S_BEQ;
               OP_J:              state_nxt = S_JUMP;
               OP_ADDIU, OP_SLTI: state_nxt = S_IEXEC;
               default:           state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_nxt = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_nxt = rdy ? S_FETCH : S_MEMWR;
         S_REXEC:  state_nxt = S_RWB;
         S_IEXEC:  state_nxt = S_IWB;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_nxt;
   end

   // Decode is gated by rst so every strobe drops the instant reset asserts.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ct_op     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      state_dbg     = 4'd0;
      if (rst) begin
         state_dbg = state;
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = rdy;
               pc_write  = rdy;
            end
            S_DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = ~op_legal;
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = rdy;
            end
            S_REXEC: begin
               alu_src_a = 1'b1;
               alu_ct_op = 2'b10;
            end
            S_RWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_BEQ: begin
               alu_src_a     = 1'b1;
               alu_ct_op     = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               instr_done    = 1'b1;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_source  = 2'b10;
               instr_done = 1'b1;
            end
            S_IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ct_op = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
            end
            S_IWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            default: state_dbg = state;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed literal checks followed by random opcodes and
// memory stalls, compared each cycle against a per-instruction route model.
module tb_mc_main_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] pc_source, alu_src_b, alu_ct_op;
   logic [3:0] state_dbg;

   mc_main_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ct_op(alu_ct_op), .instr_done(instr_done), .illegal_op(illegal_op),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // State codes visited by each instruction class, in order; -1 ends the route.
   function automatic int route_at(input logic [5:0] op, input int k);
      int s[5];
      case (op)
         6'b100011: s = '{0, 1, 2, 3, 4};
         6'b101011: s = '{0, 1, 2, 5, -1};
         6'b000000: s = '{0, 1, 6, 7, -1};
         6'b000100: s = '{0, 1, 8, -1, -1};
         6'b000010: s = '{0, 1, 9, -1, -1};
         6'b001001,
         6'b001010: s = '{0, 1, 10, 11, -1};
         default:   s = '{0, 1, -1, -1, -1};
      endcase
      return s[k];
   endfunction

   function automatic int base_latency(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b000100, 6'b000010: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_wait(input int code);
      return (code == 0) || (code == 3) || (code == 5);
   endfunction

   function automatic logic [21:0] expv(input int code, input logic [5:0] op, input logic rdy);
      logic pcw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0;
      logic rw = 0, asa = 0, dn = 0, ill = 0;
      logic [1:0] ps = 0, asb = 0, aop = 0;
      case (code)
         0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1:  begin asb = 2'b11; ill = (route_at(op, 2) < 0); end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; dn = 1; end
         5:  begin mw = 1; iod = 1; dn = rdy; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rd = 1; dn = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
         9:  begin pcw = 1; ps = 2'b10; dn = 1; end
         10: begin asa = 1; asb = 2'b10; aop = (op == 6'b001010) ? 2'b11 : 2'b00; end
         11: begin rw = 1; dn = 1; end
         default: ;
      endcase
      return {pcw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, dn, ill, 4'(code)};
   endfunction

   logic [21:0] outv;
   assign outv = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ct_op,
                  instr_done, illegal_op, state_dbg};

   // Model: position within the current instruction's route.
   int m_idx = 0;
   int mcode;
   always @(posedge clk or negedge rst) begin
      if (!rst) m_idx <= 0;
      else begin
         mcode = route_at(opcode, m_idx);
         if (is_wait(mcode) && !mem_ready) m_idx <= m_idx;
         else if (m_idx == 4 || route_at(opcode, m_idx + 1) < 0) m_idx <= 0;
         else m_idx <= m_idx + 1;
      end
   end

   // Compare process: full output vector every cycle, plus retire latency.
   int ccode;
   int ic = 0, iw = 0;
   logic [21:0] ev;
   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_outputs", 32'(outv), 32'd0);
         ic = 0;
         iw = 0;
      end else begin
         ccode = route_at(opcode, m_idx);
         ev = expv(ccode, opcode, mem_ready);
         chk("out_vec", 32'(outv), 32'(ev));
         ic++;
         if (is_wait(ccode) && !mem_ready) iw++;
         if (ev[5]) begin
            chk("latency", ic, base_latency(opcode) + iw);
            ic = 0;
            iw = 0;
         end else if (ev[4]) begin
            ic = 0;
            iw = 0;
         end
      end
   end

   task automatic tick(input logic rdy);
      @(posedge clk);
      #1 mem_ready = rdy;
      @(negedge clk);
      #1;
   endtask

   int dn, mw_cnt, n;
   int exp_r[4]  = '{1, 6, 7, 0};
   int exp_lw[6] = '{1, 2, 3, 3, 3, 4};
   logic rdy_lw[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [5:0] legal_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000010, 6'b001001, 6'b001010};

   initial begin
      rst = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("release_state", state_dbg, 0);
      chk("release_mem_read", mem_read, 1);

      // R-type
      opcode = 6'b000000; dn = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1);
         chk("r_state", state_dbg, exp_r[i]);
         dn += int'(instr_done);
         if (i == 1) chk("r_aluop", alu_ct_op, 2'b10);
         chk("r_wb_only", {reg_write, reg_dst}, (i == 2) ? 2'b11 : 2'b00);
      end
      chk("r_done_cnt", dn, 1);

      // lw with two stall cycles in MEM_RD
      opcode = 6'b100011; n = 1;
      for (int i = 0; i < 6; i++) begin
         tick(rdy_lw[i]);
         n++;
         chk("lw_state", state_dbg, exp_lw[i]);
      end
      chk("lw_mem_to_reg", mem_to_reg, 1);
      chk("lw_done", instr_done, 1);
      chk("lw_cycles", n, 7);
      tick(1'b1);
      chk("lw_back_fetch", state_dbg, 0);

      // sw then beq
      opcode = 6'b101011; mw_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1);
         mw_cnt += int'(mem_write);
         if (i == 2) chk("sw_memwr", {state_dbg, mem_write, instr_done}, {4'd5, 2'b11});
      end
      chk("sw_write_cnt", mw_cnt, 1);
      opcode = 6'b000100;
      tick(1'b1);
      tick(1'b1);
      chk("beq_ctl", {state_dbg, alu_ct_op, pc_write_cond, pc_source}, {4'd8, 2'b01, 1'b1, 2'b01});
      tick(1'b1);

      // slti then addiu
      opcode = 6'b001010;
      tick(1'b1); tick(1'b1);
      chk("slti_aluop", {state_dbg, alu_ct_op}, {4'd10, 2'b11});
      tick(1'b1);
      chk("slti_wb", {state_dbg, reg_write, reg_dst}, {4'd11, 2'b10});
      tick(1'b1);
      opcode = 6'b001001;
      tick(1'b1); tick(1'b1);
      chk("addiu_aluop", {state_dbg, alu_ct_op}, {4'd10, 2'b00});
      tick(1'b1);
      chk("addiu_wb", {state_dbg, reg_write, reg_dst}, {4'd11, 2'b10});
      tick(1'b1);

      // illegal opcode
      opcode = 6'b111111;
      tick(1'b1);
      chk("illegal_pulse", {state_dbg, illegal_op, mem_write, reg_write, pc_write},
          {4'd1, 4'b1000});
      tick(1'b1);
      chk("illegal_next", {state_dbg, illegal_op}, {4'd0, 1'b0});

      // reset while stalled in MEM_WR
      opcode = 6'b101011;
      tick(1'b1); tick(1'b1); tick(1'b0);
      chk("sw_stall_write", {state_dbg, mem_write}, {4'd5, 1'b1});
      rst = 1'b0;
      #1;
      chk("midreset_write", mem_write, 0);
      chk("midreset_state", state_dbg, 0);
      @(posedge clk); @(negedge clk);
      #1 rst = 1'b1;
      tick(1'b1);
      chk("post_reset_fetch", state_dbg, 0);

      // random phase
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         mem_ready = ($urandom_range(0, 3) != 0);
         if (m_idx == 0) begin
            if ($urandom_range(0, 4) == 0) opcode = 6'($urandom_range(0, 63));
            else opcode = legal_ops[$urandom_range(0, 6)];
         end
         if ($urandom_range(0, 249) == 0) begin
            rst = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      @(posedge clk); @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
